// File: rtl/ras_ctrl.sv
// Return-address stack controller driving an external linked-block allocator and data RAM.
// Latency: allocator/RAM commands are combinational from state and inputs; status updates next clock.
// Backpressure: ready is high only in RUN; requests arriving while ready=0 are dropped, not queued.
module ras_ctrl #(
    parameter  int DEPTH  = 1024,
    parameter  int DATA_W = 32,
    localparam int ADDR   = $clog2(DEPTH),
    localparam int CNT    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              restore,
    input  logic [ADDR-1:0]   restore_ptr,
    input  logic [CNT-1:0]    restore_cnt,
    input  logic              flush,
    output logic              ready,
    output logic [ADDR-1:0]   ckpt_ptr,
    output logic [CNT-1:0]    ckpt_cnt,
    output logic              empty,
    output logic              full,
    output logic              underflow,
    output logic              overflow,
    output logic              links_incr,
    output logic              links_decr,
    output logic              links_gen_addr,
    output logic              links_set_addr,
    output logic [ADDR-1:0]   links_addr_in,
    input  logic [ADDR-1:0]   links_addr_out,
    output logic              mem_we,
    output logic [ADDR-1:0]   mem_waddr,
    output logic [DATA_W-1:0] mem_wdata
);

    typedef enum logic [1:0] {
        S_INIT    = 2'd0,
        S_RUN     = 2'd1,
        S_RESTORE = 2'd2,
        S_FLUSH   = 2'd3
    } state_t;

    localparam logic [CNT-1:0] CNT_FULL = CNT'(DEPTH);

    state_t          state_q, state_d;
    logic [CNT-1:0]  cnt_q, cnt_d;
    logic [ADDR-1:0] ptr_q, ptr_d;
    logic            underflow_q, underflow_d;
    logic            overflow_q, overflow_d;

    // State, occupancy, checkpoint pointer and sticky error flags; synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            ptr_q       <= '0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
        end
    end

    // Next state plus the zero-latency allocator/RAM command decode; all commands held low in reset.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        ptr_d          = ptr_q;
        underflow_d    = underflow_q;
        overflow_d     = overflow_q;
        ready          = 1'b0;
        links_incr     = 1'b0;
        links_decr     = 1'b0;
        links_gen_addr = 1'b0;
        links_set_addr = 1'b0;
        links_addr_in  = '0;
        mem_we         = 1'b0;
        mem_waddr      = '0;
        mem_wdata      = push_data;

        if (reset_n) begin
            case (state_q)
                S_INIT, S_FLUSH: begin
                    // Fresh list head; occupancy was already cleared on entry.
                    links_gen_addr = 1'b1;
                    state_d        = S_RUN;
                end
                S_RESTORE: begin
                    // Dead cycle covering the allocator's read latency after set_addr.
                    state_d = S_RUN;
                end
                default: begin
                    ready = 1'b1;
                    if (flush) begin
                        cnt_d   = '0;
                        state_d = S_FLUSH;
                    end else if (restore) begin
                        links_set_addr = 1'b1;
                        links_addr_in  = restore_ptr;
                        cnt_d          = (restore_cnt > CNT_FULL) ? CNT_FULL : restore_cnt;
                        state_d        = S_RESTORE;
                    end else if (push && pop && (cnt_q != '0)) begin
                        // Return immediately followed by call: overwrite top in place.
                        mem_we    = 1'b1;
                        mem_waddr = ptr_q;
                    end else if (push) begin
                        if (pop) begin
                            underflow_d = 1'b1;
                        end
                        if (cnt_q != CNT_FULL) begin
                            links_incr = 1'b1;
                            mem_we     = 1'b1;
                            mem_waddr  = links_addr_out;
                            cnt_d      = cnt_q + 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end else if (pop) begin
                        if (cnt_q != '0) begin
                            links_decr = 1'b1;
                            cnt_d      = cnt_q - 1'b1;
                        end else begin
                            underflow_d = 1'b1;
                        end
                    end
                end
            endcase

            if (links_incr || links_decr || links_gen_addr || links_set_addr) begin
                ptr_d = links_addr_out;
            end
        end
    end

    assign ckpt_ptr  = ptr_q;
    assign ckpt_cnt  = cnt_q;
    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CNT_FULL);
    assign underflow = underflow_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_ras_ctrl.sv
// Randomized plus directed bench for ras_ctrl with a simple allocator stub.
// Latency: checks each cycle at negedge+1 against a behavioural model.
// Backpressure: model tracks the not-ready cycles after init, flush and restore.
module tb_ras_ctrl;

    localparam int DEPTH = 32;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int CW    = 6;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          push;
    logic [DW-1:0] push_data;
    logic          pop;
    logic          restore;
    logic [AW-1:0] restore_ptr;
    logic [CW-1:0] restore_cnt;
    logic          flush;
    logic          ready;
    logic [AW-1:0] ckpt_ptr;
    logic [CW-1:0] ckpt_cnt;
    logic          empty, full, underflow, overflow;
    logic          links_incr, links_decr, links_gen_addr, links_set_addr;
    logic [AW-1:0] links_addr_in;
    logic [AW-1:0] links_addr_out;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    always #5 clk = ~clk;

    ras_ctrl #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk(clk), .reset_n(reset_n), .push(push), .push_data(push_data), .pop(pop),
        .restore(restore), .restore_ptr(restore_ptr), .restore_cnt(restore_cnt), .flush(flush),
        .ready(ready), .ckpt_ptr(ckpt_ptr), .ckpt_cnt(ckpt_cnt), .empty(empty), .full(full),
        .underflow(underflow), .overflow(overflow), .links_incr(links_incr),
        .links_decr(links_decr), .links_gen_addr(links_gen_addr), .links_set_addr(links_set_addr),
        .links_addr_in(links_addr_in), .links_addr_out(links_addr_out), .mem_we(mem_we),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
    );

    // Allocator stub: next-pointer walks up on incr, down on decr, jumps on set, restarts on gen.
    logic [AW-1:0] alloc_q;
    assign links_addr_out = alloc_q;
    always @(posedge clk) begin
        if (!reset_n)            alloc_q <= '0;
        else if (links_gen_addr) alloc_q <= '0;
        else if (links_set_addr) alloc_q <= links_addr_in;
        else if (links_incr)     alloc_q <= alloc_q + 1'b1;
        else if (links_decr)     alloc_q <= alloc_q - 1'b1;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: stack occupancy, last captured pointer, sticky flags,
    // and pending not-ready cycles (one gen_addr cycle or one dead cycle).
    bit            m_gen;
    bit            m_stall;
    int            m_cnt;
    logic [AW-1:0] m_ptr;
    bit            m_uf, m_ov;

    task automatic model_reset();
        m_gen = 1; m_stall = 0; m_cnt = 0; m_ptr = '0; m_uf = 0; m_ov = 0;
    endtask

    task automatic step(input bit rn, input bit ps, input logic [DW-1:0] pd, input bit pp,
                        input bit rs, input logic [AW-1:0] rp, input logic [CW-1:0] rc,
                        input bit fl);
        bit            e_rdy, e_inc, e_dec, e_gen, e_set, e_we;
        logic [AW-1:0] e_waddr;
        bit            cmd;
        @(negedge clk);
        reset_n = rn; push = ps; push_data = pd; pop = pp;
        restore = rs; restore_ptr = rp; restore_cnt = rc; flush = fl;
        #1;
        chk("ckpt_ptr",  ckpt_ptr,  m_ptr);
        chk("ckpt_cnt",  ckpt_cnt,  m_cnt);
        chk("empty",     empty,     m_cnt == 0);
        chk("full",      full,      m_cnt == DEPTH);
        chk("underflow", underflow, m_uf);
        chk("overflow",  overflow,  m_ov);

        {e_rdy, e_inc, e_dec, e_gen, e_set, e_we} = '0;
        e_waddr = '0;
        if (!rn) begin
            // outputs quiet; state reloads at the edge
        end else if (m_gen) begin
            e_gen = 1; m_gen = 0;
        end else if (m_stall) begin
            m_stall = 0;
        end else begin
            e_rdy = 1;
            if (fl) begin
                m_cnt = 0; m_gen = 1;
            end else if (rs) begin
                e_set = 1; m_stall = 1;
                m_cnt = (int'(rc) > DEPTH) ? DEPTH : int'(rc);
            end else if (ps && pp && m_cnt > 0) begin
                e_we = 1; e_waddr = m_ptr;
            end else if (ps) begin
                if (pp) m_uf = 1;
                if (m_cnt < DEPTH) begin
                    e_inc = 1; e_we = 1; e_waddr = alloc_q; m_cnt++;
                end else begin
                    m_ov = 1;
                end
            end else if (pp) begin
                if (m_cnt > 0) begin
                    e_dec = 1; m_cnt--;
                end else begin
                    m_uf = 1;
                end
            end
        end

        chk("ready",    ready,          e_rdy);
        chk("incr",     links_incr,     e_inc);
        chk("decr",     links_decr,     e_dec);
        chk("gen_addr", links_gen_addr, e_gen);
        chk("set_addr", links_set_addr, e_set);
        chk("mem_we",   mem_we,         e_we);
        if (e_we) begin
            chk("mem_waddr", mem_waddr, e_waddr);
            chk("mem_wdata", mem_wdata, pd);
        end
        if (e_set) chk("addr_in", links_addr_in, rp);

        cmd = e_inc | e_dec | e_gen | e_set;
        if (cmd) m_ptr = alloc_q;
        if (!rn) model_reset();
    endtask

    task automatic idle();
        step(1, 0, '0, 0, 0, '0, '0, 0);
    endtask

    task automatic do_push(input logic [DW-1:0] d);
        step(1, 1, d, 0, 0, '0, '0, 0);
    endtask

    task automatic do_pop();
        step(1, 0, '0, 1, 0, '0, '0, 0);
    endtask

    logic [AW-1:0] cap_ptr;
    int            cap_cnt;

    initial begin
        reset_n = 0; push = 0; push_data = '0; pop = 0; restore = 0;
        restore_ptr = '0; restore_cnt = '0; flush = 0;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset state is checked inside the first step; INIT gen_addr there too.
        idle();
        // Three calls, then four returns.
        do_push(32'hA); do_push(32'hB); do_push(32'hC);
        idle();
        chk("d_cnt3", ckpt_cnt, 3);
        chk("d_empty0", empty, 0);
        repeat (4) do_pop();
        idle(); idle();
        chk("d_uf_sticky", underflow, 1);
        chk("d_cnt0", ckpt_cnt, 0);

        // Checkpoint at depth 2, push two more, then restore.
        do_push(32'h11); do_push(32'h22);
        cap_ptr = m_ptr; cap_cnt = m_cnt;
        do_push(32'h33); do_push(32'h44);
        step(1, 0, '0, 0, 1, cap_ptr, CW'(cap_cnt), 0);
        idle();
        idle();
        chk("d_restore_cnt", ckpt_cnt, 2);

        // Fill to full and one beyond.
        step(1, 0, '0, 0, 0, '0, '0, 1);
        idle();
        for (int i = 0; i < DEPTH + 1; i++) do_push(32'h1000 + i);
        idle();
        chk("d_full", full, 1);
        chk("d_ovf", overflow, 1);

        // flush wins over push+pop; then push+pop replaces top.
        step(1, 0, '0, 0, 0, '0, '0, 1);
        idle();
        for (int i = 0; i < 5; i++) do_push(32'h200 + i);
        step(1, 1, 32'hDEAD, 1, 0, '0, '0, 1);
        idle();
        do_push(32'h301); do_push(32'h302);
        step(1, 1, 32'hBEEF, 1, 0, '0, '0, 0);
        idle();
        chk("d_pp_cnt", ckpt_cnt, 2);

        // Saturating restore count.
        step(1, 0, '0, 0, 1, 5'd7, 6'd50, 0);
        idle(); idle();
        chk("d_sat", ckpt_cnt, DEPTH);

        // Reset mid-RESTORE and mid-FLUSH.
        step(1, 0, '0, 0, 1, 5'd3, 6'd4, 0);
        step(0, 1, 32'h5, 1, 0, '0, '0, 0);
        idle(); idle();
        step(1, 0, '0, 0, 0, '0, '0, 1);
        step(0, 0, '0, 0, 0, '0, '0, 0);
        idle(); idle();

        // Randomized traffic with push-heavy and pop-heavy phases.
        for (int n = 0; n < 3000; n++) begin
            int  r;
            int  push_pct;
            bit  rn, ps, pp, rs, fl;
            push_pct = ((n / 250) % 2 == 0) ? 70 : 30;
            r  = int'($urandom_range(0, 999));
            rn = (r != 0);
            fl = ($urandom_range(0, 99) < 2);
            rs = ($urandom_range(0, 99) < 3);
            ps = ($urandom_range(0, 99) < push_pct);
            pp = ($urandom_range(0, 99) < (100 - push_pct));
            step(rn, ps, DW'($urandom), pp, rs, AW'($urandom), CW'($urandom), fl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ras_ctrl.md
RAS_CTRL -- requirements
Module: ras_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 1024: total return-address entries managed by the linked-block allocator.
REQ-002 SHALL have parameter DATA_W, default 32: return-address width.
REQ-003 SHALL define localparam ADDR = $clog2(DEPTH) and localparam CNT = $clog2(DEPTH)+1.
REQ-004 SHALL have port clk  input  1  rising-edge clock; one clock, no other clock domains.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port push  input  1  call: push push_data.
REQ-007 SHALL have port push_data  input  DATA_W  return address to push.
REQ-008 SHALL have port pop  input  1  return: pop top entry.
REQ-009 SHALL have port restore  input  1  mispredict recovery: reload pointer and count from checkpoint.
REQ-010 SHALL have port restore_ptr  input  ADDR  checkpointed pointer.
REQ-011 SHALL have port restore_cnt  input  CNT  checkpointed occupancy.
REQ-012 SHALL have port flush  input  1  discard the whole stack.
REQ-013 SHALL have port ready  output  1  requests are accepted this cycle.
REQ-014 SHALL have port ckpt_ptr  output  ADDR  current top pointer, for checkpointing.
REQ-015 SHALL have port ckpt_cnt  output  CNT  current occupancy.
REQ-016 SHALL have ports empty, full, underflow, overflow  output  1 each  status; underflow and overflow are sticky.
REQ-017 SHALL have ports links_incr, links_decr, links_gen_addr, links_set_addr  output  1 each  allocator commands.
REQ-018 SHALL have ports links_addr_in (output, ADDR) and links_addr_out (input, ADDR)  allocator set address and next pointer.
REQ-019 SHALL have ports mem_we (output, 1), mem_waddr (output, ADDR), mem_wdata (output, DATA_W)  data-RAM write port.

Function
REQ-020 SHALL implement FSM states INIT, RUN, RESTORE, FLUSH.
REQ-021 INIT: SHALL assert links_gen_addr for exactly one cycle, then go to RUN; ready=0 during INIT.
REQ-022 RUN: ready=1; all other states: ready=0, and requests are ignored (not queued).
REQ-023 Priority in RUN: flush > restore > push/pop; a lower-priority request in the same cycle SHALL be dropped.
REQ-024 flush in RUN SHALL go to FLUSH, assert links_gen_addr for one cycle, clear cnt to 0, then go to RUN.
REQ-025 restore in RUN SHALL assert links_set_addr with links_addr_in=restore_ptr, load cnt=restore_cnt, and go to RESTORE for one cycle (allocator read latency), then go to RUN.
REQ-026 A push alone with cnt<DEPTH SHALL assert links_incr and mem_we, with mem_waddr=links_addr_out, mem_wdata=push_data, and increment cnt.
REQ-027 A pop alone with cnt>0 SHALL assert links_decr and decrement cnt.
REQ-028 Simultaneous push and pop with cnt>0 SHALL issue no links command, write push_data at ckpt_ptr, and leave cnt unchanged.
REQ-029 Simultaneous push and pop with cnt=0 SHALL behave as a push alone and set underflow.
REQ-030 A pop with cnt=0 SHALL issue no command and set underflow.
REQ-031 A push with cnt=DEPTH SHALL be dropped (no incr, no mem_we) and set overflow.
REQ-032 The ckpt_ptr register SHALL load links_addr_out on every cycle in which any links command is asserted, and hold otherwise.
REQ-033 Outputs empty=(cnt==0) and full=(cnt==DEPTH) SHALL be combinational from the registered cnt.
REQ-034 All links_* and mem_* outputs SHALL be combinational from state and inputs, at most one links command per cycle, zero latency.
REQ-035 restore_cnt greater than DEPTH SHALL saturate to DEPTH.

Reset
REQ-036 reset_n=0 at a clock edge SHALL force state=INIT, cnt=0, ckpt_ptr=0, underflow=0, overflow=0, with all links_* and mem_we driven 0 while reset_n=0, including mid-RESTORE or mid-FLUSH.
REQ-037 The first cycle after release SHALL be INIT with links_gen_addr=1.

Verification
REQ-038 Reset, then 3 pushes of 0xA,0xB,0xC -> links_incr x3, mem_wdata writes in order, cnt=3, empty=0.
REQ-039 cnt=3, then 4 pops -> links_decr x3, 4th pop issues no command, cnt=0, underflow=1 and stays 1.
REQ-040 Capture ckpt_ptr/cnt=2, push 2 more, then restore -> links_set_addr=1 with the captured pointer, ready=0 for one cycle, cnt=2.
REQ-041 DEPTH=32, 33 pushes -> full=1 after the 32nd push; the 33rd push gives mem_we=0 and overflow=1.
REQ-042 push+pop+flush in the same cycle with cnt=5 -> only FLUSH occurs (gen_addr=1), cnt=0, no mem_we; push+pop together with cnt=2 -> mem write at ckpt_ptr, cnt stays 2.
